pulse_pair_tx: RTL and testbench
================================

Name: pulse_pair_tx

Overview:
- Transmit side of the odd-pulse serial link; its serial output drives the `din` of the odd-one Mealy detector.
- Accepts an event count N over a valid/ready handshake.
- Emits N "pulse pairs" (two consecutive 1-cycles each) separated by a programmable zero gap.
- The downstream detector therefore produces exactly N single-cycle `dout` pulses.

Parameters:
CNT_W, 8, width of event count input; max N = 2^CNT_W-1
GAP_CYCLES, 2, zero cycles inserted between consecutive pairs (0 allowed = pairs back-to-back)
GAP_W, 4, width of internal gap counter; must satisfy GAP_CYCLES < 2^GAP_W

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-low reset (rst==0 at a clk edge resets)
cnt_in  input  CNT_W  number of pulse pairs to send
cnt_valid  input  1  cnt_in valid
cnt_ready  output  1  block can accept a count (registered)
dout  output  1  serial line to detector din (registered)
busy  output  1  transfer in progress (registered)
done  output  1  one-cycle pulse after final pair (registered)

Behaviour:
- Reset value of every output: dout=0, cnt_ready=0, busy=0, done=0. Internal counters are cleared.
- Reset mid-operation: the next edge with rst==0 forces all outputs to 0 and state to WARM. The remaining count is discarded and no done pulse is issued.
- States:
  - WARM: one cycle after reset release; dout=0, cnt_ready=0. Guarantees the detector leaves its idle state. Next state is IDLE.
  - IDLE: cnt_ready=1, busy=0, dout=0.
    - On cnt_valid&cnt_ready, latch cnt_in into rem; cnt_ready drops next cycle.
    - If cnt_in==0 go to DONE, otherwise go to PA.
  - PA: dout=1, busy=1. Next state is PB.
  - PB: dout=1. Decrement rem.
    - If rem (after decrement) == 0, go to DONE.
    - Else if GAP_CYCLES==0, go to PA.
    - Else load the gap counter and go to GAP.
  - GAP: dout=0 for exactly GAP_CYCLES cycles, then go to PA.
  - DONE: done=1 for exactly one cycle, dout=0, busy=1, cnt_ready=0. Next state is IDLE.
- Latency: handshake at edge k means dout=1 in the cycle starting at edge k (first PA cycle).
- Timing example, N=2, GAP_CYCLES=2, cycles counted from the accept edge as cycle 0:
  - dout: cycle 0 = 1, 1 = 1, 2 = 0, 3 = 0, 4 = 1, 5 = 1.
  - done=1 in cycle 6.
  - cnt_ready=1 from cycle 7.
- Total busy length = 2N + (N-1)*GAP_CYCLES + 1 cycles.
- cnt_valid while cnt_ready==0 is ignored; no queueing. Upstream must hold cnt_valid until accepted.
- cnt_in is sampled only at the handshake edge; later changes have no effect.
- Max N (all ones) must not wrap rem; the transfer sends exactly 2^CNT_W-1 pairs.
- Illegal state encodings recover to WARM with all outputs 0.

Decomposition:
- Package pulse_pair_tx_pkg holds:
  - state enum: WARM, IDLE, PA, PB, GAP, DONE (3-bit encoding);
  - default CNT_W, GAP_CYCLES and GAP_W constants.
- No sub-module is needed. Single clocked process plus next-state logic; the gap counter stays inline.

Test Plan:
- Reset then release → dout=0 and cnt_ready=0 in the first cycle (WARM); cnt_ready=1 from the second cycle.
- N=3, GAP=2 → dout 1,1,0,0,1,1,0,0,1,1; done pulse on the 11th cycle; cnt_ready high on the 12th. A reference detector model on dout yields exactly 3 pulses.
- N=0 → no dout activity; done=1 in the cycle after accept; cnt_ready=1 the cycle after that.
- GAP_CYCLES=0, N=2 → dout 1,1,1,1 with no zero gap between pairs; detector model yields 2 pulses.
- Drop rst to 0 during the 2nd pair of an N=5 transfer → next cycle dout=0, busy=0, done never asserted; after release, WARM then IDLE; a new N=1 transfer works.
- Toggle cnt_valid with changing cnt_in while busy → ignored; N=255 → 510 ones counted, done once, no wrap.

Source files
------------

// File: rtl/pulse_pair_tx_pkg.sv
// rtl/pulse_pair_tx_pkg.sv - shared state encoding and default sizing for pulse_pair_tx
package pulse_pair_tx_pkg;

   typedef enum logic [2:0] {
      WARM = 3'd0,
      IDLE = 3'd1,
      PA   = 3'd2,
      PB   = 3'd3,
      GAP  = 3'd4,
      DONE = 3'd5
   } state_t;

   localparam int CNT_W_DEF      = 8;
   localparam int GAP_CYCLES_DEF = 2;
   localparam int GAP_W_DEF      = 4;

endpackage

// File: rtl/pulse_pair_tx.sv
// rtl/pulse_pair_tx.sv - emits N pulse pairs with programmable zero gaps on a serial line
module pulse_pair_tx
   import pulse_pair_tx_pkg::*;
#(
   parameter int CNT_W      = CNT_W_DEF,
   parameter int GAP_CYCLES = GAP_CYCLES_DEF,
   parameter int GAP_W      = GAP_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [CNT_W-1:0] cnt_in,
   input  logic             cnt_valid,
   output logic             cnt_ready,
   output logic             dout,
   output logic             busy,
   output logic             done
);

   // Gap counter counts down to zero, so it is loaded with one less than the gap length.
   localparam logic [GAP_W-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] rem_q, rem_d;
   logic [GAP_W-1:0] gap_q, gap_d;
   logic             dout_d, busy_d, done_d, ready_d;

   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      gap_d   = gap_q;
      case (state_q)
         WARM: state_d = IDLE;
         IDLE: begin
            if (cnt_valid) begin
               rem_d   = cnt_in;
               state_d = (cnt_in == '0) ? DONE : PA;
            end
         end
         PA: state_d = PB;
         PB: begin
            rem_d = rem_q - CNT_W'(1);
            if (rem_d == '0) begin
               state_d = DONE;
            end else if (GAP_CYCLES == 0) begin
               state_d = PA;
            end else begin
               gap_d   = GAP_LOAD;
               state_d = GAP;
            end
         end
         GAP: begin
            if (gap_q == '0) begin
               state_d = PA;
            end else begin
               gap_d = gap_q - GAP_W'(1);
            end
         end
         DONE: state_d = IDLE;
         default: begin
            state_d = WARM;
            rem_d   = '0;
            gap_d   = '0;
         end
      endcase
   end

   // Outputs are registered decodes of the state being entered, so they line up with it.
   always_comb begin
      dout_d  = (state_d == PA) || (state_d == PB);
      busy_d  = (state_d == PA) || (state_d == PB) || (state_d == GAP) || (state_d == DONE);
      done_d  = (state_d == DONE);
      ready_d = (state_d == IDLE);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= WARM;
         rem_q     <= '0;
         gap_q     <= '0;
         dout      <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         cnt_ready <= 1'b0;
      end else begin
         state_q   <= state_d;
         rem_q     <= rem_d;
         gap_q     <= gap_d;
         dout      <= dout_d;
         busy      <= busy_d;
         done      <= done_d;
         cnt_ready <= ready_d;
      end
   end

endmodule

// File: tb/tb_pulse_pair_tx.sv
// tb/tb_pulse_pair_tx.sv - self-checking bench for pulse_pair_tx against a pulse-train model
module tb_pulse_pair_tx;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] cnt_in2 = '0, cnt_in0 = '0;
   logic       cnt_valid2 = 1'b0, cnt_valid0 = 1'b0;
   logic       cnt_ready2, dout2, busy2, done2;
   logic       cnt_ready0, dout0, busy0, done0;

   int  checks = 0;
   int  errors = 0;
   bit  sel = 1'b0;

   logic o_dout, o_busy, o_done, o_ready;
   assign o_dout  = sel ? dout0 : dout2;
   assign o_busy  = sel ? busy0 : busy2;
   assign o_done  = sel ? done0 : done2;
   assign o_ready = sel ? cnt_ready0 : cnt_ready2;

   always #5 clk = ~clk;

   pulse_pair_tx dut2 (
      .clk(clk), .rst(rst), .cnt_in(cnt_in2), .cnt_valid(cnt_valid2),
      .cnt_ready(cnt_ready2), .dout(dout2), .busy(busy2), .done(done2)
   );

   pulse_pair_tx #(.GAP_CYCLES(0)) dut0 (
      .clk(clk), .rst(rst), .cnt_in(cnt_in0), .cnt_valid(cnt_valid0),
      .cnt_ready(cnt_ready0), .dout(dout0), .busy(busy0), .done(done0)
   );

   task automatic drive(input bit v, input logic [7:0] c);
      if (sel) begin
         cnt_valid0 = v;
         cnt_in0    = c;
      end else begin
         cnt_valid2 = v;
         cnt_in2    = c;
      end
   endtask

   task automatic wait_ready(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (o_ready === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL wait_ready: cnt_ready=%b after 50 cycles, required 1", o_ready);
      end
   endtask

   // Expected line waveform from accept: N pairs of ones, G zeros between pairs.
   task automatic build_expect(input int n, input int g, output bit q[$]);
      q = {};
      for (int i = 0; i < n; i++) begin
         q.push_back(1'b1);
         q.push_back(1'b1);
         if (i < n - 1)
            for (int j = 0; j < g; j++) q.push_back(1'b0);
      end
   endtask

   task automatic run_xfer(input bit which, input int n, input bit toggle);
      bit q[$];
      bit ok;
      int ones, pulses, g;
      sel  = which;
      g    = which ? 0 : 2;
      build_expect(n, g, q);
      wait_ready(ok);
      if (!ok) return;
      drive(1'b1, 8'(n));
      @(posedge clk);
      #1 drive(1'b0, 8'($urandom));
      ones   = 0;
      pulses = 0;
      for (int c = 0; c < q.size(); c++) begin
         @(negedge clk);
         checks++;
         if (o_dout !== q[c] || o_busy !== 1'b1 || o_done !== 1'b0 || o_ready !== 1'b0) begin
            errors++;
            $display("FAIL xfer n=%0d g=%0d cycle %0d: dout/busy/done/ready=%b%b%b%b required %b100",
                     n, g, c, o_dout, o_busy, o_done, o_ready, q[c]);
         end
         if (o_dout === 1'b1) begin
            ones++;
            if (ones % 2 == 0) pulses++;
         end
         if (toggle) drive(1'($urandom), 8'($urandom));
      end
      @(negedge clk);
      checks++;
      if (o_done !== 1'b1 || o_dout !== 1'b0 || o_busy !== 1'b1 || o_ready !== 1'b0) begin
         errors++;
         $display("FAIL done_cycle n=%0d: done/dout/busy/ready=%b%b%b%b required 1010",
                  n, o_done, o_dout, o_busy, o_ready);
      end
      drive(1'b0, 8'($urandom));
      @(negedge clk);
      checks++;
      if (o_ready !== 1'b1 || o_busy !== 1'b0 || o_done !== 1'b0 || o_dout !== 1'b0) begin
         errors++;
         $display("FAIL after_done n=%0d: ready/busy/done/dout=%b%b%b%b required 1000",
                  n, o_ready, o_busy, o_done, o_dout);
      end
      checks++;
      if (pulses != n || ones != 2 * n) begin
         errors++;
         $display("FAIL detector n=%0d: pulses=%0d ones=%0d required %0d and %0d",
                  n, pulses, ones, n, 2 * n);
      end
   endtask

   task automatic test_reset;
      rst = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({dout2, busy2, done2, cnt_ready2, dout0, busy0, done0, cnt_ready0} !== 8'b0) begin
         errors++;
         $display("FAIL reset_state: outputs=%b required 00000000",
                  {dout2, busy2, done2, cnt_ready2, dout0, busy0, done0, cnt_ready0});
      end
      @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      checks++;
      if (cnt_ready2 !== 1'b0 || dout2 !== 1'b0 || cnt_ready0 !== 1'b0) begin
         errors++;
         $display("FAIL warm_cycle: ready2=%b dout2=%b ready0=%b required 0", cnt_ready2, dout2, cnt_ready0);
      end
      @(negedge clk);
      checks++;
      if (cnt_ready2 !== 1'b1 || busy2 !== 1'b0 || cnt_ready0 !== 1'b1) begin
         errors++;
         $display("FAIL idle_after_warm: ready2=%b busy2=%b ready0=%b required 1 0 1", cnt_ready2, busy2, cnt_ready0);
      end
   endtask

   task automatic test_mid_reset;
      bit q[$];
      bit ok;
      sel = 1'b0;
      build_expect(5, 2, q);
      wait_ready(ok);
      if (!ok) return;
      drive(1'b1, 8'd5);
      @(posedge clk);
      #1 drive(1'b0, 8'd0);
      for (int c = 0; c <= 4; c++) begin
         @(negedge clk);
         checks++;
         if (o_dout !== q[c] || o_done !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_pre cycle %0d: dout=%b done=%b required %b 0", c, o_dout, o_done, q[c]);
         end
      end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (dout2 !== 1'b0 || busy2 !== 1'b0 || done2 !== 1'b0 || cnt_ready2 !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset_clear: dout/busy/done/ready=%b%b%b%b required 0000",
                  dout2, busy2, done2, cnt_ready2);
      end
      @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      checks++;
      if (cnt_ready2 !== 1'b0 || done2 !== 1'b0 || dout2 !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset_warm: ready=%b done=%b dout=%b required 000", cnt_ready2, done2, dout2);
      end
      @(negedge clk);
      checks++;
      if (cnt_ready2 !== 1'b1 || done2 !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset_idle: ready=%b done=%b required 1 0", cnt_ready2, done2);
      end
      run_xfer(1'b0, 1, 1'b0);
   endtask

   task automatic test_random;
      for (int t = 0; t < 8; t++)
         run_xfer(1'($urandom), int'($urandom_range(0, 12)), 1'($urandom));
   endtask

   initial begin
      test_reset;
      run_xfer(1'b0, 3, 1'b0);
      run_xfer(1'b0, 0, 1'b0);
      run_xfer(1'b1, 2, 1'b0);
      run_xfer(1'b1, 0, 1'b1);
      test_mid_reset;
      run_xfer(1'b0, 4, 1'b1);
      run_xfer(1'b0, 255, 1'b1);
      run_xfer(1'b1, 255, 1'b0);
      test_random;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
